// File: rtl/alu_pkg.sv
// Shared types and constants for the EX-stage ALU and its decoder.
package alu_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CTRL_W  = 4;
  localparam int unsigned SHAMT_W = 5;

  // {bit3, funct3} codes emitted by the ALU decoder
  typedef enum logic [CTRL_W-1:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b1000,
    OP_SLL  = 4'b0001,
    OP_SLT  = 4'b0010,
    OP_SLTU = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_SRA  = 4'b1101,
    OP_OR   = 4'b0110,
    OP_AND  = 4'b0111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } alu_state_e;

  // Bit 3 only matters for funct3 000 and 101, so shifts are decoded on funct3
  function automatic logic is_shift(input logic [CTRL_W-1:0] ctrl);
    return (ctrl[2:0] == 3'b001) || (ctrl[2:0] == 3'b101);
  endfunction

endpackage

// File: rtl/alu_exec_if.sv
// Operand/result handshake bundle between the EX-stage front end and alu_exec.
interface alu_exec_if
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] ALUControl;
  logic [WIDTH-1:0]  SrcA;
  logic [WIDTH-1:0]  SrcB;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  ALUResult;
  logic              Zero;

  modport master (
    output in_valid, ALUControl, SrcA, SrcB, out_ready,
    input  in_ready, out_valid, ALUResult, Zero
  );

  modport slave (
    input  in_valid, ALUControl, SrcA, SrcB, out_ready,
    output in_ready, out_valid, ALUResult, Zero
  );
endinterface

// File: rtl/alu_shift_serial.sv
// One-bit-per-cycle shifter: loads on start, shifts while run and count is nonzero.
module alu_shift_serial
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               run,
  input  logic               left,
  input  logic               arith,
  input  logic [WIDTH-1:0]   a,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [WIDTH-1:0]   next_c,
  output logic               last_c
);

  logic [WIDTH-1:0]   acc;
  logic [SHAMT_W-1:0] count;
  logic               left_q;
  logic               arith_q;

  // Next accumulator value; the FSM takes it directly on the final step
  always_comb begin
    next_c = acc;
    if (left_q) next_c = {acc[WIDTH-2:0], 1'b0};
    else        next_c = {arith_q & acc[WIDTH-1], acc[WIDTH-1:1]};
  end

  assign last_c = (count == SHAMT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      count   <= '0;
      left_q  <= 1'b0;
      arith_q <= 1'b0;
    end else if (start) begin
      acc     <= a;
      count   <= shamt;
      left_q  <= left;
      arith_q <= arith;
    end else if (run && (count != '0)) begin
      acc   <= next_c;
      count <= count - SHAMT_W'(1);
    end
  end

endmodule

// File: rtl/alu_exec.sv
// Multi-cycle EX-stage ALU with valid/ready on both sides.
// ALU_BARREL_SHIFT_EN: single-cycle barrel shifts instead of the serial shifter.
module alu_exec
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic     clk,
  input  logic     rst,
  alu_exec_if.slave bus
);

  alu_state_e         state;
  alu_state_e         state_next;
  logic [WIDTH-1:0]   result;
  logic [WIDTH-1:0]   result_next;
  logic [WIDTH-1:0]   compute_c;
  logic [WIDTH-1:0]   sra_c;
  logic [2:0]         funct3;
  logic               alt;
  logic [SHAMT_W-1:0] shamt;

  assign funct3 = bus.ALUControl[2:0];
  assign alt    = bus.ALUControl[3];
  assign shamt  = bus.SrcB[SHAMT_W-1:0];
  // Kept in its own assignment so the arithmetic shift stays signed
  assign sra_c  = $unsigned($signed(bus.SrcA) >>> shamt);

`ifndef ALU_BARREL_SHIFT_EN
  logic             op_shift;
  logic             shift_start_c;
  logic             shift_last_c;
  logic [WIDTH-1:0] shift_next_c;

  assign op_shift = is_shift(bus.ALUControl);

  alu_shift_serial #(.WIDTH(WIDTH)) u_shift (
    .clk    (clk),
    .rst    (rst),
    .start  (shift_start_c),
    .run    (state == SHIFT),
    .left   (funct3 == 3'b001),
    .arith  (alt),
    .a      (bus.SrcA),
    .shamt  (shamt),
    .next_c (shift_next_c),
    .last_c (shift_last_c)
  );
`endif

  // Single-cycle datapath; serial builds only use the shift arms for shamt 0
  always_comb begin
    compute_c = '0;
    case (funct3)
      3'b000:  compute_c = alt ? (bus.SrcA - bus.SrcB) : (bus.SrcA + bus.SrcB);
`ifdef ALU_BARREL_SHIFT_EN
      3'b001:  compute_c = bus.SrcA << shamt;
      3'b101:  compute_c = alt ? sra_c : (bus.SrcA >> shamt);
`else
      3'b001:  compute_c = bus.SrcA;
      3'b101:  compute_c = alt ? sra_c : bus.SrcA;
`endif
      3'b010:  compute_c = WIDTH'($signed(bus.SrcA) < $signed(bus.SrcB));
      3'b011:  compute_c = WIDTH'(bus.SrcA < bus.SrcB);
      3'b100:  compute_c = bus.SrcA ^ bus.SrcB;
      3'b110:  compute_c = bus.SrcA | bus.SrcB;
      3'b111:  compute_c = bus.SrcA & bus.SrcB;
      default: compute_c = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      result <= '0;
    end else begin
      state  <= state_next;
      result <= result_next;
    end
  end

  always_comb begin
    state_next  = state;
    result_next = result;
`ifndef ALU_BARREL_SHIFT_EN
    shift_start_c = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
`ifdef ALU_BARREL_SHIFT_EN
          result_next = compute_c;
          state_next  = DONE;
`else
          if (op_shift && (shamt != '0)) begin
            shift_start_c = 1'b1;
            state_next    = SHIFT;
          end else begin
            result_next = compute_c;
            state_next  = DONE;
          end
`endif
        end
      end
      SHIFT: begin
`ifdef ALU_BARREL_SHIFT_EN
        state_next = IDLE;
`else
        // Final shift lands straight in the result register
        if (shift_last_c) begin
          result_next = shift_next_c;
          state_next  = DONE;
        end
`endif
      end
      DONE: begin
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.ALUResult = result;
  assign bus.Zero      = (result == '0);

endmodule

// File: tb/tb_alu_exec.sv
// Directed self-checking bench for alu_exec (serial or barrel shift build).
module tb_alu_exec;
  import alu_pkg::*;

`ifdef ALU_BARREL_SHIFT_EN
  localparam int SERIAL = 0;
`else
  localparam int SERIAL = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  alu_exec_if #(.WIDTH(32)) bus ();

  alu_exec #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input string tag, input logic [3:0] ctrl,
                          input logic [31:0] a, input logic [31:0] b);
    bus.ALUControl = ctrl;
    bus.SrcA       = a;
    bus.SrcB       = b;
    bus.in_valid   = 1'b1;
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag, output int lat);
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      chk({tag, "_busy_in_ready"}, 32'(bus.in_ready), 32'd0);
      step();
      lat++;
    end
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
  endtask

  task automatic finish_op(input string tag);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk({tag, "_post_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_post_in_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [3:0] ctrl,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat);
    int lat;
    start_op(tag, ctrl, a, b);
    wait_result(tag, lat);
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_result"}, bus.ALUResult, exp);
    chk({tag, "_zero"}, 32'(bus.Zero), 32'(exp == 32'd0));
    finish_op(tag);
  endtask

  initial begin
    int lat;
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b0;
    bus.ALUControl = 4'b0000;
    bus.SrcA       = '0;
    bus.SrcB       = '0;
    step();
    step();
    rst = 1'b0;

    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result", bus.ALUResult, 32'd0);
    chk("rst_zero", 32'(bus.Zero), 32'd1);

    run_op("add_ovf", 4'b0000, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1);
    run_op("sub_beq", 4'b1000, 32'h0000_1234, 32'h0000_1234, 32'h0, 1);
    run_op("slt_neg", 4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
    run_op("sltu_big", 4'b0011, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
    run_op("slt_alias", 4'b1010, 32'd1, 32'd2, 32'd1, 1);
    run_op("xor", 4'b0100, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 1);
    run_op("or_alias", 4'b1110, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1);
    run_op("and", 4'b0111, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1);
    run_op("sra4", 4'b1101, 32'h8000_0000, 32'd4, 32'hF800_0000, SERIAL ? 5 : 1);
    run_op("srl31", 4'b0101, 32'h8000_0000, 32'd31, 32'h0000_0001, SERIAL ? 32 : 1);
    run_op("sll31_alias", 4'b1001, 32'h0000_0001, 32'd31, 32'h8000_0000, SERIAL ? 32 : 1);
    run_op("srl_one", 4'b0101, 32'hF000_000F, 32'd1, 32'h7800_0007, SERIAL ? 2 : 1);

    // shamt 0 via B=0x20, then backpressure with a competing request
    start_op("sll0", 4'b0001, 32'h0000_ABCD, 32'h0000_0020);
    wait_result("sll0", lat);
    chk("sll0_latency", 32'(lat), 32'd1);
    chk("sll0_result", bus.ALUResult, 32'h0000_ABCD);
    bus.ALUControl = 4'b0000;
    bus.SrcA       = 32'd5;
    bus.SrcB       = 32'd6;
    bus.in_valid   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_result", bus.ALUResult, 32'h0000_ABCD);
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    finish_op("sll0");

    // Abort a long shift with reset on cycle 10
    start_op("abort", 4'b0101, 32'hFFFF_FFFF, 32'd31);
    for (int i = 0; i < 8; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_result", bus.ALUResult, 32'd0);
    chk("abort_zero", 32'(bus.Zero), 32'd1);
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    chk("abort_stays_idle", 32'(bus.out_valid), 32'd0);

    run_op("add_after_rst", 4'b0000, 32'd2, 32'd3, 32'd5, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec.md
# alu_exec

Multi-cycle execute unit for the pipelined core's EX stage. It consumes the 4-bit `ALUControl` code produced by the ALU decoder, along with two operands, and returns `ALUResult` and `Zero`. Shifts run serially (one bit per cycle) to save area; all other operations complete in one cycle. Valid/ready handshakes on both sides let the hazard unit stall the front end while a shift is in flight.

## Interface
- `WIDTH`, 32, operand/result width; shift amount is `SrcB[4:0]`
- `clk`  in  1  core clock
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  operands and `ALUControl` valid
- `in_ready`  out  1  unit can accept; high only in IDLE
- `ALUControl`  in  4  `{bit3, funct3}` op code from the ALU decoder
- `SrcA`  in  WIDTH  operand A / shift source
- `SrcB`  in  WIDTH  operand B / shift amount
- `out_valid`  out  1  `ALUResult`/`Zero` valid
- `out_ready`  in  1  consumer accepts result
- `ALUResult`  out  WIDTH  registered result
- `Zero`  out  1  `ALUResult == 0`, decoded from the result register

## Operation
- Op codes:
  - 0000 add
  - 1000 sub (also used for beq/bne)
  - x001 sll
  - x010 slt (signed)
  - x011 sltu
  - x100 xor
  - 0101 srl
  - 1101 sra
  - x110 or
  - x111 and
- Bit 3 is significant only for funct3 000 and 101. Otherwise it is ignored; 1010 behaves as 0010.
- Arithmetic wraps modulo 2^WIDTH.
- slt/sltu produce `{WIDTH-1 zeros, flag}`.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`, capture the inputs.
  - Non-shift op: compute, load `ALUResult`, go to DONE.
  - Shift with shamt=0: load `ALUResult`=`SrcA`, go to DONE.
  - Shift with shamt>0: load accumulator=`SrcA`, count=shamt, go to SHIFT.
- SHIFT:
  - Each cycle, shift the accumulator one bit (left fill 0; right fill 0 for srl, `acc[WIDTH-1]` for sra) and decrement count.
  - When count reaches 0, `ALUResult`=accumulator and go to DONE.
  - `in_valid` is ignored in this state.
- DONE:
  - `out_valid`=1; `ALUResult` is stable.
  - On `out_ready`, go to IDLE.
  - `out_valid` holds while `out_ready`=0.
- No overlap: a new operation is accepted only in IDLE, so back-to-back ops take at least 2 cycles each.
- Reset values: state=IDLE, `ALUResult`=0, `Zero`=1, `out_valid`=0, `in_ready`=1, count=0.
- Reset mid-SHIFT or in DONE aborts the operation. No result is emitted, and the result is not preserved.

## Timing
- Accept is the edge where `in_valid && in_ready`.
- Non-shift op or shamt=0: `out_valid` rises 1 cycle after accept.
- Shift: `out_valid` rises 1+shamt cycles after accept; worst case is 32 cycles.
- Result handoff is the edge where `out_valid && out_ready`. `in_ready` is high the following cycle.
- All outputs are registered or decoded directly from state; there is no input-to-output combinational path.

## Configuration
- `ALU_BARREL_SHIFT_EN` defined:
  - Shifts are computed in IDLE by a barrel shifter and go straight to DONE with 1-cycle latency.
  - The SHIFT state and counter are removed.
- `ALU_BARREL_SHIFT_EN` undefined: shifts use the serial behaviour described under Operation.
- Results are identical in both configurations; only latency differs.

## Structure
- Shared package `alu_pkg` holds:
  - the `alu_op_e` enum of the ten op codes above, shared with the ALU decoder;
  - the `alu_state_e` FSM enum;
  - constant `SHAMT_W = 5`.
- Sub-module `alu_shift_serial` contains the accumulator, counter and fill logic, with start/done handshake to the FSM. It is not instantiated when `ALU_BARREL_SHIFT_EN` is defined.

## Test plan
- Add: 0000, A=0x7FFFFFFF, B=1 → `ALUResult`=0x80000000, `Zero`=0, `out_valid` 1 cycle after accept.
- Sub for branch: 1000, A=B=0x1234 → `ALUResult`=0, `Zero`=1.
- Signed vs unsigned compare:
  - 0010, A=0xFFFFFFFF, B=1 → 1.
  - 0011 with the same operands → 0.
- Arithmetic shift right: 1101, A=0x80000000, B=4 → 0xF8000000 after 5 cycles (1 cycle with `ALU_BARREL_SHIFT_EN`). `in_ready`=0 throughout.
- Shift edge cases and backpressure:
  - 0001, B=0x20 (shamt 0), A=0xABCD → 0xABCD in 1 cycle.
  - Hold `out_ready`=0 for 3 cycles → `out_valid` and `ALUResult` stable; `in_valid` is ignored.
- Reset mid-op: start 0101, A=0xFFFFFFFF, B=31; assert `rst` on cycle 10 → next cycle `out_valid`=0, `ALUResult`=0, `Zero`=1, `in_ready`=1. The following add is processed normally.
